regfile_bypass_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 86 ++++++++
 rtl/regfile_bypass_sb.sv | 107 ++++++++++
 tb/tb_regfile_bypass_sb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register file with bypass and scoreboard.
//   DEF_DATA_W / DEF_DEPTH : default entry width and entry count
//   DEF_INIT0 / DEF_INIT1  : default reset values of entries 0 and 1
//   addr_t / data_t        : address and data types for the default configuration
//   addr_bits()            : address width for a given depth (never below 1 bit)
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_INIT0  = 1;
    localparam int DEF_INIT1  = 2;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

    // A single-entry file still needs a one-bit address port.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Pending-bit scoreboard for the register file.
//   clk, n_rst        : clock, asynchronous active-low reset
//   ra                : packed read addresses, port k in slice k
//   fwd               : per read port, the operand is being forwarded this cycle
//   we0/wa0, we1/wa1  : write enables and addresses (a write clears pending)
//   iss_v/iss_a       : issue, marks iss_a pending
//   rpend             : registered pending bit of each read address
//   stall             : some read operand is pending and not forwarded
//   pend_cnt          : registered number of pending entries
module rf_scoreboard import regfile_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = addr_bits(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    input  logic [NUM_RD-1:0]        fwd,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_a,
    output logic [NUM_RD-1:0]        rpend,
    output logic                     stall,
    output logic [CNT_W-1:0]         pend_cnt
);

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [CNT_W-1:0] n_add;
    logic [CNT_W-1:0] n_rem;

    // Set is applied after clear so an issue racing a write to the same
    // entry leaves it pending: the issued instruction is the newer producer.
    // Addresses at or beyond DEPTH match no entry and so are ignored.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            set_vec[i] = iss_v && (iss_a == ADDR_W'(i));
            clr_vec[i] = (we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)));
        end
        pend_next = set_vec | (pend & ~clr_vec);
    end

    // The count moves by the bits that actually flip, so it tracks the
    // population exactly and can never wrap.
    always_comb begin
        n_add = '0;
        n_rem = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_add = n_add + CNT_W'(pend_next[i] & ~pend[i]);
            n_rem = n_rem + CNT_W'(pend[i] & ~pend_next[i]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= pend_cnt + n_add - n_rem;
        end
    end

    // Out-of-range read addresses match no entry and report not pending.
    always_comb begin
        rpend = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ra[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    rpend[k] = pend[i];
                end
            end
        end
        stall = |(rpend & ~fwd);
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb
// Register file with two write ports, NUM_RD combinational read ports,
// optional write-to-read forwarding and a pending-bit scoreboard.
//   clk, n_rst        : clock, asynchronous active-low reset
//   ra / rd           : packed read addresses / read data, port k in slice k
//   rpend             : pending bit of each read address
//   stall             : a read operand is pending and not forwarded
//   we0, wa0, wd0     : write port 0
//   we1, wa1, wd1     : write port 1 (wins on an address collision)
//   iss_v, iss_a      : issue, marks iss_a pending
//   pend_cnt          : number of pending entries
module regfile_bypass_sb import regfile_pkg::*; #(
    parameter int          DATA_W = DEF_DATA_W,
    parameter int          DEPTH  = DEF_DEPTH,
    parameter int          NUM_RD = 2,
    parameter int          BYPASS = 1,
    parameter int unsigned INIT0  = DEF_INIT0,
    parameter int unsigned INIT1  = DEF_INIT1,
    localparam int         ADDR_W = addr_bits(DEPTH),
    localparam int         CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rpend,
    output logic                     stall,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_a,
    output logic [CNT_W-1:0]         pend_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_RD-1:0] fwd;

    // Port 1 is evaluated last so it wins a same-address collision.
    // Out-of-range write addresses match no entry and are dropped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? DATA_W'(INIT0) :
                          (i == 1) ? DATA_W'(INIT1) : '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we0 && (wa0 == ADDR_W'(i))) begin
                    mem[i] <= wd0;
                end
                if (we1 && (wa1 == ADDR_W'(i))) begin
                    mem[i] <= wd1;
                end
            end
        end
    end

    // Forwarding is suppressed in reset so reads show the reset contents.
    // Unmatched (out-of-range) addresses read as zero and never forward.
    always_comb begin
        rd  = '0;
        fwd = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ra[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    rd[k*DATA_W +: DATA_W] = mem[i];
                    if ((BYPASS != 0) && n_rst) begin
                        if (we0 && (wa0 == ADDR_W'(i))) begin
                            rd[k*DATA_W +: DATA_W] = wd0;
                            fwd[k] = 1'b1;
                        end
                        if (we1 && (wa1 == ADDR_W'(i))) begin
                            rd[k*DATA_W +: DATA_W] = wd1;
                            fwd[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk      (clk),
        .n_rst    (n_rst),
        .ra       (ra),
        .fwd      (fwd),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .rpend    (rpend),
        .stall    (stall),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb
// Bench for regfile_bypass_sb. Group 0 drives two instances of the default
// configuration (one with forwarding, one without); group 1 drives a
// DATA_W=64, DEPTH=12, NUM_RD=3 instance. An array model predicts every
// output each cycle, and directed literal checks pin the key scenarios.
module tb_regfile_bypass_sb;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    int unsigned ra_s   [2][3];
    logic        we0_s  [2];
    logic        we1_s  [2];
    logic        iss_v_s[2];
    int unsigned wa0_s  [2];
    int unsigned wa1_s  [2];
    int unsigned iss_a_s[2];
    logic [63:0] wd0_s  [2];
    logic [63:0] wd1_s  [2];

    int n_vec  = 0;
    int n_miss = 0;

    logic [5:0]   ra_a;
    logic [63:0]  rd_a, rd_b;
    logic [1:0]   rpend_a, rpend_b;
    logic         stall_a, stall_b;
    logic [3:0]   cnt_a, cnt_b;
    logic [11:0]  ra_c;
    logic [191:0] rd_c;
    logic [2:0]   rpend_c;
    logic         stall_c;
    logic [3:0]   cnt_c;

    assign ra_a = {3'(ra_s[0][1]), 3'(ra_s[0][0])};
    assign ra_c = {4'(ra_s[1][2]), 4'(ra_s[1][1]), 4'(ra_s[1][0])};

    regfile_bypass_sb dut_a (
        .clk(clk), .n_rst(n_rst), .ra(ra_a), .rd(rd_a), .rpend(rpend_a), .stall(stall_a),
        .we0(we0_s[0]), .wa0(3'(wa0_s[0])), .wd0(wd0_s[0][31:0]),
        .we1(we1_s[0]), .wa1(3'(wa1_s[0])), .wd1(wd1_s[0][31:0]),
        .iss_v(iss_v_s[0]), .iss_a(3'(iss_a_s[0])), .pend_cnt(cnt_a)
    );

    regfile_bypass_sb #(.BYPASS(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .ra(ra_a), .rd(rd_b), .rpend(rpend_b), .stall(stall_b),
        .we0(we0_s[0]), .wa0(3'(wa0_s[0])), .wd0(wd0_s[0][31:0]),
        .we1(we1_s[0]), .wa1(3'(wa1_s[0])), .wd1(wd1_s[0][31:0]),
        .iss_v(iss_v_s[0]), .iss_a(3'(iss_a_s[0])), .pend_cnt(cnt_b)
    );

    regfile_bypass_sb #(.DATA_W(64), .DEPTH(12), .NUM_RD(3)) dut_c (
        .clk(clk), .n_rst(n_rst), .ra(ra_c), .rd(rd_c), .rpend(rpend_c), .stall(stall_c),
        .we0(we0_s[1]), .wa0(4'(wa0_s[1])), .wd0(wd0_s[1]),
        .we1(we1_s[1]), .wa1(4'(wa1_s[1])), .wd1(wd1_s[1]),
        .iss_v(iss_v_s[1]), .iss_a(4'(iss_a_s[1])), .pend_cnt(cnt_c)
    );

    // Model state: contents, pending flags and pending count per group.
    logic [63:0] mrf  [2][16];
    bit          mpend[2][16];
    int          mcnt [2];

    function automatic int dep(input int g);
        return (g == 0) ? 8 : 12;
    endfunction

    function automatic int nrd(input int g);
        return (g == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] dmask(input int g);
        return (g == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic void model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 16; i++) begin
                mrf[g][i]   = 64'd0;
                mpend[g][i] = 1'b0;
            end
            mrf[g][0] = 64'd1;
            mrf[g][1] = 64'd2;
            mcnt[g]   = 0;
        end
    endfunction

    // One clock edge: write 0, then write 1 (port 1 wins), then the issue
    // (newest producer wins); the count is a fresh population count.
    function automatic void model_step();
        for (int g = 0; g < 2; g++) begin
            if (we0_s[g] && wa0_s[g] < dep(g)) begin
                mrf[g][wa0_s[g]]   = wd0_s[g] & dmask(g);
                mpend[g][wa0_s[g]] = 1'b0;
            end
            if (we1_s[g] && wa1_s[g] < dep(g)) begin
                mrf[g][wa1_s[g]]   = wd1_s[g] & dmask(g);
                mpend[g][wa1_s[g]] = 1'b0;
            end
            if (iss_v_s[g] && iss_a_s[g] < dep(g)) begin
                mpend[g][iss_a_s[g]] = 1'b1;
            end
            mcnt[g] = 0;
            for (int i = 0; i < dep(g); i++) begin
                mcnt[g] += int'(mpend[g][i]);
            end
        end
    endfunction

    function automatic bit hit(input int g, input int unsigned a, input bit byp);
        return byp && n_rst && ((we0_s[g] && wa0_s[g] == a) || (we1_s[g] && wa1_s[g] == a));
    endfunction

    function automatic logic [63:0] exp_rd(input int g, input int k, input bit byp);
        int unsigned a;
        logic [63:0] v;
        a = ra_s[g][k];
        if (a >= dep(g)) return 64'd0;
        v = mrf[g][a];
        if (byp && n_rst && we0_s[g] && wa0_s[g] == a) v = wd0_s[g] & dmask(g);
        if (byp && n_rst && we1_s[g] && wa1_s[g] == a) v = wd1_s[g] & dmask(g);
        return v;
    endfunction

    function automatic logic exp_rpend(input int g, input int k);
        int unsigned a;
        a = ra_s[g][k];
        return (a < dep(g)) ? mpend[g][a] : 1'b0;
    endfunction

    function automatic logic exp_stall(input int g, input bit byp);
        logic s;
        s = 1'b0;
        for (int k = 0; k < nrd(g); k++) begin
            if (exp_rpend(g, k) && !hit(g, ra_s[g][k], byp)) s = 1'b1;
        end
        return s;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) model_reset();
        else        model_step();
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Every falling edge, all outputs of all three instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("a_rd%0d", k), {32'd0, rd_a[k*32 +: 32]}, exp_rd(0, k, 1'b1));
            checkOutput($sformatf("b_rd%0d", k), {32'd0, rd_b[k*32 +: 32]}, exp_rd(0, k, 1'b0));
            checkOutput($sformatf("a_rpend%0d", k), {63'd0, rpend_a[k]}, {63'd0, exp_rpend(0, k)});
            checkOutput($sformatf("b_rpend%0d", k), {63'd0, rpend_b[k]}, {63'd0, exp_rpend(0, k)});
        end
        checkOutput("a_stall", {63'd0, stall_a}, {63'd0, exp_stall(0, 1'b1)});
        checkOutput("b_stall", {63'd0, stall_b}, {63'd0, exp_stall(0, 1'b0)});
        checkOutput("a_cnt", {60'd0, cnt_a}, 64'(mcnt[0]));
        checkOutput("b_cnt", {60'd0, cnt_b}, 64'(mcnt[0]));
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("c_rd%0d", k), rd_c[k*64 +: 64], exp_rd(1, k, 1'b1));
            checkOutput($sformatf("c_rpend%0d", k), {63'd0, rpend_c[k]}, {63'd0, exp_rpend(1, k)});
        end
        checkOutput("c_stall", {63'd0, stall_c}, {63'd0, exp_stall(1, 1'b1)});
        checkOutput("c_cnt", {60'd0, cnt_c}, 64'(mcnt[1]));
    end

    task automatic idleAll();
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 3; k++) ra_s[g][k] = 0;
            we0_s[g] = 1'b0; wa0_s[g] = 0; wd0_s[g] = 64'd0;
            we1_s[g] = 1'b0; wa1_s[g] = 0; wd1_s[g] = 64'd0;
            iss_v_s[g] = 1'b0; iss_a_s[g] = 0;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        idleAll();
    endtask

    task automatic applyStimulus(input int g,
                                 input int unsigned r0, input int unsigned r1, input int unsigned r2,
                                 input logic w0, input int unsigned a0, input logic [63:0] d0,
                                 input logic w1, input int unsigned a1, input logic [63:0] d1,
                                 input logic iv, input int unsigned ia);
        ra_s[g][0] = r0; ra_s[g][1] = r1; ra_s[g][2] = r2;
        we0_s[g] = w0; wa0_s[g] = a0; wd0_s[g] = d0;
        we1_s[g] = w1; wa1_s[g] = a1; wd1_s[g] = d1;
        iss_v_s[g] = iv; iss_a_s[g] = ia;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        idleAll();

        // Traffic during reset must be discarded and not forwarded.
        nextCycle();
        applyStimulus(0, 0, 1, 0, 1, 0, 64'h99, 0, 0, 0, 1, 3);
        applyStimulus(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_rd0", {32'd0, rd_a[31:0]}, 64'd1);
        checkOutput("rst_rd1", {32'd0, rd_a[63:32]}, 64'd2);
        checkOutput("rst_cnt", {60'd0, cnt_a}, 64'd0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("post_rst_rd0", {32'd0, rd_a[31:0]}, 64'd1);

        // Same-address collision: port 1 wins, forwarded then stored.
        nextCycle();
        applyStimulus(0, 3, 3, 0, 1, 3, 64'hAAAA, 1, 3, 64'h5555, 0, 0);
        @(negedge clk);
        checkOutput("coll_fwd", {32'd0, rd_a[31:0]}, 64'h5555);
        checkOutput("coll_nofwd", {32'd0, rd_b[31:0]}, 64'h0);
        nextCycle();
        applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("coll_stored", {32'd0, rd_a[31:0]}, 64'h5555);

        // Scoreboard set then clear on entry 4.
        nextCycle();
        applyStimulus(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        checkOutput("iss4_same", {62'd0, rpend_a}, 64'd0);
        nextCycle();
        applyStimulus(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("iss4_rpend", {62'd0, rpend_a}, 64'd1);
        checkOutput("iss4_cnt", {60'd0, cnt_a}, 64'd1);
        checkOutput("iss4_stall", {63'd0, stall_a}, 64'd1);
        nextCycle();
        applyStimulus(0, 4, 0, 0, 1, 4, 64'h44, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wr4_stall_byp", {63'd0, stall_a}, 64'd0);
        checkOutput("wr4_stall_nobyp", {63'd0, stall_b}, 64'd1);
        nextCycle();
        applyStimulus(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wr4_rpend", {62'd0, rpend_a}, 64'd0);
        checkOutput("wr4_cnt", {60'd0, cnt_a}, 64'd0);

        // Issue and write racing on entry 6, then on different entries.
        nextCycle();
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        nextCycle();
        applyStimulus(0, 6, 0, 0, 1, 6, 64'h66, 0, 0, 0, 1, 6);
        nextCycle();
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("race6_rpend", {62'd0, rpend_a}, 64'd1);
        checkOutput("race6_cnt", {60'd0, cnt_a}, 64'd1);
        nextCycle();
        applyStimulus(0, 6, 2, 0, 1, 6, 64'h67, 0, 0, 0, 1, 2);
        nextCycle();
        applyStimulus(0, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("swap_rpend", {62'd0, rpend_a}, 64'h2);
        checkOutput("swap_cnt", {60'd0, cnt_a}, 64'd1);

        // Pending entry 5 forwarded from write port 1.
        nextCycle();
        applyStimulus(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        nextCycle();
        applyStimulus(0, 5, 0, 0, 0, 0, 0, 1, 5, 64'h55, 0, 0);
        @(negedge clk);
        checkOutput("fwd5_stall_byp", {63'd0, stall_a}, 64'd0);
        checkOutput("fwd5_stall_nobyp", {63'd0, stall_b}, 64'd1);
        checkOutput("fwd5_cnt", {60'd0, cnt_a}, 64'd2);

        // Two writes clearing two pending entries in one edge.
        nextCycle();
        applyStimulus(0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        nextCycle();
        applyStimulus(0, 2, 3, 0, 1, 2, 64'h22, 1, 3, 64'h33, 0, 0);
        nextCycle();
        applyStimulus(0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("dual_clr_cnt", {60'd0, cnt_a}, 64'd0);

        // Load entries 0/1/5 of the wide instance so the reset is visible.
        nextCycle();
        applyStimulus(1, 0, 1, 5, 1, 0, 64'hF0, 1, 5, 64'hF5, 1, 5);
        nextCycle();
        applyStimulus(1, 0, 1, 5, 1, 1, 64'hF1, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("c_pre_rd2", rd_c[191:128], 64'hF5);
        checkOutput("c_pre_cnt", {60'd0, cnt_c}, 64'd1);

        // Mid-run reset takes effect without waiting for a clock edge.
        nextCycle();
        applyStimulus(0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        n_rst = 1'b0;
        #1;
        checkOutput("mid_rst_a5", {32'd0, rd_a[31:0]}, 64'd0);
        checkOutput("mid_rst_c0", rd_c[63:0], 64'd1);
        checkOutput("mid_rst_c1", rd_c[127:64], 64'd2);
        checkOutput("mid_rst_c5", rd_c[191:128], 64'd0);
        checkOutput("mid_rst_cnt", {60'd0, cnt_c}, 64'd0);
        nextCycle();
        @(negedge clk);
        #2 n_rst = 1'b1;

        // Wide instance: address 13 is out of range, three independent reads.
        nextCycle();
        applyStimulus(1, 13, 0, 0, 1, 13, 64'hDEAD, 0, 0, 0, 1, 13);
        @(negedge clk);
        checkOutput("c13_rd", rd_c[63:0], 64'd0);
        nextCycle();
        applyStimulus(1, 13, 11, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("c13_rd_after", rd_c[63:0], 64'd0);
        checkOutput("c13_cnt", {60'd0, cnt_c}, 64'd0);
        nextCycle();
        applyStimulus(1, 11, 7, 0, 1, 11, 64'h0123_4567_89AB_CDEF, 1, 7, 64'h7777, 1, 13);
        @(negedge clk);
        checkOutput("c_fwd_rd0", rd_c[63:0], 64'h0123_4567_89AB_CDEF);
        checkOutput("c_fwd_rd1", rd_c[127:64], 64'h7777);
        checkOutput("c_fwd_rd2", rd_c[191:128], 64'd1);
        nextCycle();
        applyStimulus(1, 11, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("c_st_rd0", rd_c[63:0], 64'h0123_4567_89AB_CDEF);
        checkOutput("c_st_rd1", rd_c[127:64], 64'h7777);
        checkOutput("c_st_cnt", {60'd0, cnt_c}, 64'd0);

        nextCycle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
